alu_issue_unit: RTL and testbench

- Issue front-end for the 4-stage ALU/register-bank pipeline; the producer end of its instruction interface.
- Buffers packed instruction words in a small FIFO and drives rs1/rs2/rd/func/addr plus an issue-valid qualifier, one instruction per cycle.
- The pipeline has no forwarding, so this block enforces read-after-write spacing with a destination scoreboard and inserts bubbles.

---
 rtl/alu_issue_pkg.sv | 41 ++++
 rtl/alu_issue_unit_fifo.sv | 50 +++++
 rtl/alu_issue_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue front-end: instruction layout,
// function codes and operand-use decode.
package alu_issue_pkg;

    localparam int INSTR_W  = 24;
    localparam int FUNC_LSB = 20;
    localparam int RD_LSB   = 16;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 8;
    localparam int ADDR_LSB = 0;
    localparam int FUNC_W   = 4;
    localparam int REG_W    = 4;
    localparam int ADDR_W   = 8;

    localparam logic [FUNC_W-1:0] ADD  = 4'd0;
    localparam logic [FUNC_W-1:0] SUB  = 4'd1;
    localparam logic [FUNC_W-1:0] AND  = 4'd2;
    localparam logic [FUNC_W-1:0] MOV  = 4'd3;
    localparam logic [FUNC_W-1:0] LDB  = 4'd4;
    localparam logic [FUNC_W-1:0] OR   = 4'd5;
    localparam logic [FUNC_W-1:0] XOR  = 4'd6;
    localparam logic [FUNC_W-1:0] CMP  = 4'd7;
    localparam logic [FUNC_W-1:0] NOT  = 4'd8;
    localparam logic [FUNC_W-1:0] STB  = 4'd9;
    localparam logic [FUNC_W-1:0] SHL  = 4'd10;
    localparam logic [FUNC_W-1:0] SHR  = 4'd11;
    localparam logic [FUNC_W-1:0] SHLA = 4'd12;
    localparam logic [FUNC_W-1:0] SHLB = 4'd13;

    localparam logic [FUNC_W-1:0] NOP_FUNC    = MOV;
    localparam logic [FUNC_W-1:0] ILLEGAL_MIN = 4'd14;

    function automatic logic uses_rs1(input logic [FUNC_W-1:0] func);
        return func inside {ADD, SUB, AND, OR, XOR, CMP, MOV, NOT, SHL, SHR};
    endfunction

    function automatic logic uses_rs2(input logic [FUNC_W-1:0] func);
        return func inside {ADD, SUB, AND, OR, XOR, CMP, LDB, STB, SHLA, SHLB};
    endfunction

endpackage

// File: rtl/alu_issue_unit_fifo.sv
// issue_fifo: DEPTH x W synchronous FIFO with head visible combinationally,
// so the issue decision can look at the oldest word in the same cycle.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (push) mem_reg[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front-end: FIFO-buffered instructions, RAW scoreboard with bubble
// insertion, registered iss_* outputs. Optional stats via ISSUE_STATS_EN.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int HAZ_DEPTH = 2
`ifdef ISSUE_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               iss_valid,
    output logic [FUNC_W-1:0]  iss_func,
    output logic [REG_W-1:0]   iss_rd,
    output logic [REG_W-1:0]   iss_rs1,
    output logic [REG_W-1:0]   iss_rs2,
    output logic [ADDR_W-1:0]  iss_addr,
    output logic               illegal,
    output logic               busy
`ifdef ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]   stat_issued,
    output logic [CNT_W-1:0]   stat_stalls,
    output logic [CNT_W-1:0]   stat_illegal
`endif
);
    logic [INSTR_W-1:0]      head;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_instr),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    logic [FUNC_W-1:0] head_func;
    logic [REG_W-1:0]  head_rd;
    logic [REG_W-1:0]  head_rs1;
    logic [REG_W-1:0]  head_rs2;
    logic [ADDR_W-1:0] head_addr;

    assign head_func = head[FUNC_LSB +: FUNC_W];
    assign head_rd   = head[RD_LSB   +: REG_W];
    assign head_rs1  = head[RS1_LSB  +: REG_W];
    assign head_rs2  = head[RS2_LSB  +: REG_W];
    assign head_addr = head[ADDR_LSB +: ADDR_W];

    logic             sb_v_reg   [HAZ_DEPTH];
    logic [REG_W-1:0] sb_rd_reg  [HAZ_DEPTH];
    logic             sb_v_next  [HAZ_DEPTH];
    logic [REG_W-1:0] sb_rd_next [HAZ_DEPTH];

    logic hazard;
    logic any_pending;
    logic head_illegal;
    logic do_issue;
    logic do_drop;
    logic do_stall;

    // Entry k holds a destination issued k+1 cycles ago. It becomes readable
    // HAZ_DEPTH cycles after issue, so only the younger HAZ_DEPTH-1 entries
    // block; the oldest one only keeps busy asserted until writeback.
    always_comb begin
        hazard      = 1'b0;
        any_pending = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            any_pending = any_pending | sb_v_reg[i];
            if (i < HAZ_DEPTH - 1 && sb_v_reg[i] &&
                ((uses_rs1(head_func) && sb_rd_reg[i] == head_rs1) ||
                 (uses_rs2(head_func) && sb_rd_reg[i] == head_rs2)))
                hazard = 1'b1;
        end
    end

    assign head_illegal = (head_func >= ILLEGAL_MIN);
    assign do_drop      = !fifo_empty && head_illegal;
    assign do_stall     = !fifo_empty && !head_illegal && hazard;
    assign do_issue     = !fifo_empty && !head_illegal && !hazard;
    assign pop          = do_drop || do_issue;
    assign busy         = (fifo_count != '0) || any_pending;

    for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_sb
        if (gi == 0) begin : g_in
            assign sb_v_next[gi]  = do_issue;
            assign sb_rd_next[gi] = head_rd;
        end else begin : g_shift
            assign sb_v_next[gi]  = sb_v_reg[gi-1];
            assign sb_rd_next[gi] = sb_rd_reg[gi-1];
        end
    end

    always_ff @(posedge clk1) begin
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (!rst_n) begin
                sb_v_reg[i]  <= 1'b0;
                sb_rd_reg[i] <= '0;
            end else begin
                sb_v_reg[i]  <= sb_v_next[i];
                sb_rd_reg[i] <= sb_rd_next[i];
            end
        end
    end

    logic              iss_valid_reg;
    logic [FUNC_W-1:0] iss_func_reg;
    logic [REG_W-1:0]  iss_rd_reg;
    logic [REG_W-1:0]  iss_rs1_reg;
    logic [REG_W-1:0]  iss_rs2_reg;
    logic [ADDR_W-1:0] iss_addr_reg;
    logic              illegal_reg;

    // Fields only load on an issue so they hold through bubbles.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            iss_valid_reg <= 1'b0;
            iss_func_reg  <= NOP_FUNC;
            iss_rd_reg    <= '0;
            iss_rs1_reg   <= '0;
            iss_rs2_reg   <= '0;
            iss_addr_reg  <= '0;
            illegal_reg   <= 1'b0;
        end else begin
            iss_valid_reg <= do_issue;
            illegal_reg   <= do_drop;
            if (do_issue) begin
                iss_func_reg <= head_func;
                iss_rd_reg   <= head_rd;
                iss_rs1_reg  <= head_rs1;
                iss_rs2_reg  <= head_rs2;
                iss_addr_reg <= head_addr;
            end
        end
    end

    assign iss_valid = iss_valid_reg;
    assign iss_func  = iss_func_reg;
    assign iss_rd    = iss_rd_reg;
    assign iss_rs1   = iss_rs1_reg;
    assign iss_rs2   = iss_rs2_reg;
    assign iss_addr  = iss_addr_reg;
    assign illegal   = illegal_reg;

`ifdef ISSUE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stat_issued_reg;
    logic [CNT_W-1:0] stat_stalls_reg;
    logic [CNT_W-1:0] stat_illegal_reg;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            stat_issued_reg  <= '0;
            stat_stalls_reg  <= '0;
            stat_illegal_reg <= '0;
        end else begin
            if (do_issue && stat_issued_reg != CNT_MAX)
                stat_issued_reg <= stat_issued_reg + CNT_W'(1);
            if (do_stall && stat_stalls_reg != CNT_MAX)
                stat_stalls_reg <= stat_stalls_reg + CNT_W'(1);
            if (do_drop && stat_illegal_reg != CNT_MAX)
                stat_illegal_reg <= stat_illegal_reg + CNT_W'(1);
        end
    end

    assign stat_issued  = stat_issued_reg;
    assign stat_stalls  = stat_stalls_reg;
    assign stat_illegal = stat_illegal_reg;
`else
    logic unused_stall;
    assign unused_stall = do_stall;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit (DEPTH=4, HAZ_DEPTH=2); stat checks
// are compiled in when ISSUE_STATS_EN is defined.
module tb_alu_issue_unit;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_instr = '0;
    logic        in_ready;
    logic        iss_valid;
    logic [3:0]  iss_func;
    logic [3:0]  iss_rd;
    logic [3:0]  iss_rs1;
    logic [3:0]  iss_rs2;
    logic [7:0]  iss_addr;
    logic        illegal;
    logic        busy;
`ifdef ISSUE_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_stalls;
    logic [15:0] stat_illegal;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_issue_unit #(.DEPTH(4), .HAZ_DEPTH(2)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .iss_valid (iss_valid),
        .iss_func  (iss_func),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_addr  (iss_addr),
        .illegal   (illegal),
        .busy      (busy)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_stalls  (stat_stalls),
        .stat_illegal (stat_illegal)
`endif
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (iss_valid)
            $display("issue: func=%0d rd=%0d rs1=%0d rs2=%0d addr=%02h",
                     iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr);
        if (illegal)
            $display("drop: illegal instruction");
    end

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [7:0] addr);
        return {f, rd, rs1, rs2, addr};
    endfunction

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [23:0] w);
        in_valid = v;
        in_instr = w;
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0);
        step(1'b0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (iss_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", iss_valid); end
        compared++; if (iss_func !== 4'd3) begin mismatched++; $display("FAIL reset_func: got %0d want 3", iss_func); end
        compared++; if ({iss_rd, iss_rs1, iss_rs2, iss_addr} !== 20'h0) begin mismatched++; $display("FAIL reset_fields: got %h want 0", {iss_rd, iss_rs1, iss_rs2, iss_addr}); end
        compared++; if ({illegal, busy, in_ready} !== 3'b001) begin mismatched++; $display("FAIL reset_flags: got %b want 001", {illegal, busy, in_ready}); end
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h10));
        compared++; if (iss_valid !== 1'b0) begin mismatched++; $display("FAIL single_early: got %b want 0", iss_valid); end
        step(1'b0, '0);
        compared++; if (iss_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid: got %b want 1", iss_valid); end
        compared++; if ({iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr} !== 24'h051210) begin mismatched++; $display("FAIL single_fields: got %h want 051210", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}); end
        step(1'b0, '0);
        compared++; if ({iss_valid, busy} !== 2'b01) begin mismatched++; $display("FAIL single_busy1: got %b want 01", {iss_valid, busy}); end
        compared++; if (iss_rd !== 4'd5) begin mismatched++; $display("FAIL single_hold: got %0d want 5", iss_rd); end
        step(1'b0, '0);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(k < 4, mk(4'd0, 4'(8 + k), 4'd1, 4'd2, 8'(k)));
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_ready[%0d]: got %b want 1", k, in_ready); end
            if (k >= 1 && k <= 4) begin
                compared++; if ({iss_valid, iss_rd} !== {1'b1, 4'(8 + k - 1)}) begin mismatched++; $display("FAIL stream_issue[%0d]: got %b/%0d want 1/%0d", k, iss_valid, iss_rd, 8 + k - 1); end
            end else begin
                compared++; if (iss_valid !== 1'b0) begin mismatched++; $display("FAIL stream_idle[%0d]: got %b want 0", k, iss_valid); end
            end
        end
    endtask

    task automatic test_dependency();
        do_reset();
        step(1'b1, mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h00));
        step(1'b1, mk(4'd1, 4'd6, 4'd5, 4'd2, 8'h01));
        compared++; if ({iss_valid, iss_rd} !== {1'b1, 4'd5}) begin mismatched++; $display("FAIL dep_i0: got %b/%0d want 1/5", iss_valid, iss_rd); end
        step(1'b0, '0);
        compared++; if (iss_valid !== 1'b0) begin mismatched++; $display("FAIL dep_bubble: got %b want 0", iss_valid); end
        step(1'b0, '0);
        compared++; if ({iss_valid, iss_rd, iss_rs1} !== {1'b1, 4'd6, 4'd5}) begin mismatched++; $display("FAIL dep_i1: got %b/%0d/%0d want 1/6/5", iss_valid, iss_rd, iss_rs1); end
`ifdef ISSUE_STATS_EN
        compared++; if ({stat_stalls, stat_issued} !== {16'd1, 16'd2}) begin mismatched++; $display("FAIL dep_stats: got %0d/%0d want 1/2", stat_stalls, stat_issued); end
`endif
    endtask

    task automatic test_unused_src();
        do_reset();
        step(1'b1, mk(4'd0, 4'd7, 4'd1, 4'd2, 8'h20));
        step(1'b1, mk(4'd4, 4'd6, 4'd7, 4'd3, 8'h21));
        compared++; if ({iss_valid, iss_rd} !== {1'b1, 4'd7}) begin mismatched++; $display("FAIL unused_i0: got %b/%0d want 1/7", iss_valid, iss_rd); end
        step(1'b0, '0);
        compared++; if ({iss_valid, iss_func, iss_addr} !== {1'b1, 4'd4, 8'h21}) begin mismatched++; $display("FAIL unused_i1: got %b/%0d/%h want 1/4/21", iss_valid, iss_func, iss_addr); end
    endtask

    task automatic test_illegal();
        do_reset();
        step(1'b1, mk(4'd15, 4'd1, 4'd2, 4'd3, 8'h55));
        step(1'b1, mk(4'd0, 4'd4, 4'd1, 4'd2, 8'h66));
        compared++; if ({illegal, iss_valid} !== 2'b10) begin mismatched++; $display("FAIL illegal_pulse: got %b want 10", {illegal, iss_valid}); end
        step(1'b0, '0);
        compared++; if ({illegal, iss_valid, iss_addr} !== {2'b01, 8'h66}) begin mismatched++; $display("FAIL illegal_next: got %b/%h want 01/66", {illegal, iss_valid}, iss_addr); end
`ifdef ISSUE_STATS_EN
        compared++; if (stat_illegal !== 16'd1) begin mismatched++; $display("FAIL illegal_stat: got %0d want 1", stat_illegal); end
`endif
    endtask

    task automatic test_full_reset();
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, mk(4'd0, 4'd1, 4'd1, 4'd1, 8'(k)));
        compared++; if ({in_ready, iss_valid, busy} !== 3'b001) begin mismatched++; $display("FAIL full_state: got %b want 001", {in_ready, iss_valid, busy}); end
`ifdef ISSUE_STATS_EN
        compared++; if (stat_stalls !== 16'd3) begin mismatched++; $display("FAIL full_stalls: got %0d want 3", stat_stalls); end
`endif
        step(1'b1, mk(4'd2, 4'd9, 4'd9, 4'd9, 8'hAA));
        compared++; if ({in_ready, iss_valid, iss_addr} !== {2'b11, 8'h03}) begin mismatched++; $display("FAIL full_ignored: got %b/%h want 11/03", {in_ready, iss_valid}, iss_addr); end
        rst_n = 1'b0;
        step(1'b0, '0);
        rst_n = 1'b1;
        compared++; if ({iss_valid, iss_func, iss_rd, iss_addr, illegal, busy, in_ready} !== {1'b0, 4'd3, 4'd0, 8'h00, 3'b001}) begin mismatched++; $display("FAIL midreset_state: got %b/%0d/%0d/%h/%b want 0/3/0/00/001", iss_valid, iss_func, iss_rd, iss_addr, {illegal, busy, in_ready}); end
        step(1'b0, '0);
        step(1'b0, '0);
        compared++; if ({iss_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL midreset_empty: got %b want 00", {iss_valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_dependency();
        test_unused_src();
        test_illegal();
        test_full_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
